// File: rtl/alu_mult_sequencer.sv
// Iterative signed WIDTH x WIDTH shift-and-add multiplier with its own sequencing FSM.
// Returns the low WIDTH bits of the product plus ZERO/OVERFLOW flags in ALU format.
module alu_mult_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             OVERFLOW
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;
    logic [AW-1:0]     acc;
    logic              neg;

    logic [AW-1:0]     addend;
    logic [AW-1:0]     acc_sum;
    logic [AW-1:0]     prod;
    logic              last;
    logic              load;

    // Next accumulator value and the sign-corrected product it would complete to.
    always_comb begin
        addend  = '0;
        if (mplier[0]) begin
            addend = {{WIDTH{1'b0}}, mcand} << count;
        end
        acc_sum = acc + addend;
        prod    = neg ? -acc_sum : acc_sum;
        last    = (count == CW'(WIDTH - 1));
        load    = START && ((state == IDLE) || (state == DONE_ST));
    end

    // Sequencer: operands are captured as magnitudes; sign is reapplied at completion.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            count    <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            RESULT   <= '0;
            ZERO     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE, DONE_ST: begin
                    if (load) begin
                        mcand  <= DATA1[WIDTH-1] ? -DATA1 : DATA1;
                        mplier <= DATA2[WIDTH-1] ? -DATA2 : DATA2;
                        neg    <= DATA1[WIDTH-1] ^ DATA2[WIDTH-1];
                        acc    <= '0;
                        count  <= '0;
                        BUSY   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last) begin
                        state    <= DONE_ST;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        RESULT   <= prod[WIDTH-1:0];
                        ZERO     <= ~(|prod[WIDTH-1:0]);
                        OVERFLOW <= ~((&prod[AW-1:WIDTH-1]) | ~(|prod[AW-1:WIDTH-1]));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed self-checking bench for alu_mult_sequencer at WIDTH=8.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_alu_mult_sequencer;
    localparam int unsigned WIDTH = 8;
    localparam int LIMIT = 20;

    logic             CLK;
    logic             RESET;
    logic             START;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;
    logic             ZERO;
    logic             OVERFLOW;

    int passed;
    int total;

    alu_mult_sequencer #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .DATA1    (DATA1),
        .DATA2    (DATA2),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT),
        .ZERO     (ZERO),
        .OVERFLOW (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset;
        RESET = 1'b0;
        START = 1'b0;
        DATA1 = '0;
        DATA2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({BUSY, DONE, RESULT, ZERO, OVERFLOW} !== 12'h000)
            $display("FAIL reset_outputs got=%h exp=000", {BUSY, DONE, RESULT, ZERO, OVERFLOW});
        else passed++;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // Products table: operands, expected RESULT, ZERO, OVERFLOW (hand-computed).
    task automatic test_products;
        logic [7:0] a  [8];
        logic [7:0] b  [8];
        logic [7:0] er [8];
        logic       ez [8];
        logic       eo [8];
        int n;
        a[0]=8'd5;    b[0]=8'hFF; er[0]=8'hFB; ez[0]=0; eo[0]=0;
        a[1]=8'd16;   b[1]=8'd16; er[1]=8'h00; ez[1]=1; eo[1]=1;
        a[2]=8'h80;   b[2]=8'hFF; er[2]=8'h80; ez[2]=0; eo[2]=1;
        a[3]=8'hF4;   b[3]=8'd10; er[3]=8'h88; ez[3]=0; eo[3]=0;
        a[4]=8'd0;    b[4]=8'hFB; er[4]=8'h00; ez[4]=1; eo[4]=0;
        a[5]=8'd127;  b[5]=8'd127;er[5]=8'h01; ez[5]=0; eo[5]=1;
        a[6]=8'h80;   b[6]=8'd1;  er[6]=8'h80; ez[6]=0; eo[6]=0;
        a[7]=8'hFD;   b[7]=8'hFB; er[7]=8'h0F; ez[7]=0; eo[7]=0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            DATA1 = a[i];
            DATA2 = b[i];
            START = 1'b1;
            @(posedge CLK);
            #1;
            START = 1'b0;
            DATA1 = 8'hAA;
            DATA2 = 8'h55;
            total++;
            if (BUSY !== 1'b1) $display("FAIL busy_rise[%0d] got=%b exp=1", i, BUSY);
            else passed++;
            n = 0;
            while (n < LIMIT) begin
                @(posedge CLK);
                #1;
                n++;
                if (DONE) break;
            end
            total++;
            if (n !== 8) $display("FAIL latency[%0d] got=%0d exp=8", i, n);
            else passed++;
            total++;
            if (BUSY !== 1'b0) $display("FAIL busy_fall[%0d] got=%b exp=0", i, BUSY);
            else passed++;
            total++;
            if ({RESULT, ZERO, OVERFLOW} !== {er[i], ez[i], eo[i]})
                $display("FAIL product[%0d] got=%h/%b/%b exp=%h/%b/%b",
                         i, RESULT, ZERO, OVERFLOW, er[i], ez[i], eo[i]);
            else passed++;
            @(posedge CLK);
            #1;
            total++;
            if ({DONE, RESULT} !== {1'b0, er[i]})
                $display("FAIL done_pulse[%0d] got=%b/%h exp=0/%h", i, DONE, RESULT, er[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge CLK);
        DATA1 = 8'd7;
        DATA2 = 8'd3;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        n = 0;
        while (n < LIMIT) begin
            @(posedge CLK);
            #1;
            n++;
            if (n == 3) begin
                DATA1 = 8'd2;
                DATA2 = 8'd2;
                START = 1'b1;
            end else begin
                START = 1'b0;
            end
            if (DONE) break;
        end
        total++;
        if (n !== 8) $display("FAIL ignore_latency got=%0d exp=8", n);
        else passed++;
        total++;
        if (RESULT !== 8'd21) $display("FAIL ignore_result got=%0d exp=21", RESULT);
        else passed++;
        // Hold START through DONE_ST for an immediate reload.
        DATA1 = 8'd2;
        DATA2 = 8'd2;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        total++;
        if ({BUSY, DONE, RESULT} !== {1'b1, 1'b0, 8'd21})
            $display("FAIL b2b_load got=%b/%b/%0d exp=1/0/21", BUSY, DONE, RESULT);
        else passed++;
        n = 0;
        while (n < LIMIT) begin
            @(posedge CLK);
            #1;
            n++;
            if (DONE) break;
        end
        total++;
        if (n !== 8) $display("FAIL b2b_latency got=%0d exp=8", n);
        else passed++;
        total++;
        if ({RESULT, ZERO, OVERFLOW} !== {8'd4, 1'b0, 1'b0})
            $display("FAIL b2b_result got=%0d/%b/%b exp=4/0/0", RESULT, ZERO, OVERFLOW);
        else passed++;
    endtask

    task automatic test_reset_mid_run;
        int n;
        int seen;
        @(negedge CLK);
        DATA1 = 8'd9;
        DATA2 = 8'd9;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        total++;
        if ({BUSY, DONE, RESULT, ZERO, OVERFLOW} !== 12'h000)
            $display("FAIL abort_outputs got=%h exp=000", {BUSY, DONE, RESULT, ZERO, OVERFLOW});
        else passed++;
        @(negedge CLK);
        RESET = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL abort_no_done got=%0d exp=0", seen);
        else passed++;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        n = 0;
        while (n < LIMIT) begin
            @(posedge CLK);
            #1;
            n++;
            if (DONE) break;
        end
        total++;
        if (n !== 8) $display("FAIL restart_latency got=%0d exp=8", n);
        else passed++;
        total++;
        if ({RESULT, ZERO, OVERFLOW} !== {8'h51, 1'b0, 1'b0})
            $display("FAIL restart_result got=%h/%b/%b exp=51/0/0", RESULT, ZERO, OVERFLOW);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_products();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
